panel_volume_ctrl: RTL
======================

// Module: panel_volume_ctrl
// PURPOSE
//  Front-panel volume/mute controller driven by the debounced rotary encoder event outputs (stb/click/dir/switch).
//  Keeps a saturating target volume with step acceleration, toggles mute on switch press, and accepts CPU overrides.
//  Ramps vol_out toward the effective goal at a fixed rate (no zipper noise) and raises an IRQ on panel-originated changes.
//  Sits between rotaryEncoder and the audio gain stage / CPU register file.
// PARAMETERS
//  VOL_W        8          width of volume values
//  VOL_MAX      255        saturation ceiling for target_vol (must be <= 2**VOL_W-1)
//  VOL_DEFAULT  128        target_vol after reset
//  ACCEL_WINDOW 2400000    clk cycles; same-direction click within window uses ACCEL_STEP
//  ACCEL_STEP   4          accelerated step size (normal step is 1)
//  RAMP_DIV     1024       clk cycles per 1-LSB vol_out ramp step
// PORTS
//  clk             in   1      system clock
//  reset           in   1      asynchronous, active-high reset
//  enc_stb         in   1      encoder state-change strobe, 1 cycle
//  enc_click       in   1      detent click qualifier, valid with enc_stb
//  enc_clockwise   in   1      1=clockwise (volume up), valid with enc_stb
//  enc_switch      in   1      push-switch level, valid with enc_stb
//  cpu_vol_wr_stb  in   1      CPU write strobe for target_vol
//  cpu_vol_wr_data in   VOL_W  CPU target value (clamped to VOL_MAX)
//  cpu_mute_wr_stb in   1      CPU write strobe for mute
//  cpu_mute_wr_data in  1      CPU mute value
//  irq_ack         in   1      CPU clears vol_change_irq
//  target_vol      out  VOL_W  requested volume
//  vol_out         out  VOL_W  ramped volume to gain stage
//  mute            out  1      mute state
//  ramping         out  1      1 while vol_out != goal
//  vol_change_irq  out  1      sticky panel-change interrupt
// BEHAVIOUR
//  Reset: target_vol=VOL_DEFAULT, vol_out=0, mute=0, irq=0, sw_last=0, accel timer saturated (no accel), FSM=IDLE.
//  Click event = enc_stb & enc_click. Step = ACCEL_STEP if previous click same direction and timer < ACCEL_WINDOW, else 1.
//  Accel timer: cleared to 0 on every click event, else increments, saturating at ACCEL_WINDOW; last_dir updated on click.
//  target_vol += step (cw) or -= step (ccw), saturating at VOL_MAX / 0; takes effect the cycle after the event.
//  Switch press = enc_stb & enc_switch & ~sw_last; toggles mute. sw_last <= enc_switch on every enc_stb.
//  Click and press in same enc_stb: both applied.
//  CPU vol write same cycle as click: CPU wins, click dropped (accel timer/last_dir still update). Same rule for mute.
//  vol_change_irq set next cycle when encoder changes target_vol or mute (saturated no-change: no set). CPU writes never set it.
//  irq_ack clears it; set wins over simultaneous ack.
//  goal = mute ? 0 : target_vol. FSM states IDLE, UP, DOWN:
//   IDLE: vol_out==goal; divider held 0. goal>vol_out -> UP; goal<vol_out -> DOWN (next cycle).
//   UP/DOWN: divider counts 0..RAMP_DIV-1; at terminal count vol_out +/-1 toward goal, divider wraps.
//   Goal re-evaluated each cycle: reversal switches UP<->DOWN without resetting divider; vol_out==goal -> IDLE.
//  First step lands RAMP_DIV cycles after leaving IDLE. ramping = (state != IDLE).
//  Reset asserted mid-ramp: all state returns to reset values immediately; no partial step.
// TESTING (RAMP_DIV=4, ACCEL_WINDOW=16, ACCEL_STEP=4, VOL_MAX=255, VOL_DEFAULT=128)
//  Release reset, no input -> vol_out ramps 0..128, one LSB per 4 clk, ramping falls when vol_out=128.
//  3 cw clicks 40 cycles apart -> target 129,130,131; two cw clicks 5 cycles apart -> +1 then +4; irq set, ack clears it.
//  target=254, accelerated cw click -> target=255; further cw click -> stays 255, irq not set.
//  enc_stb with switch 0->1 -> mute=1, vol_out ramps to 0; repeat press -> mute=0, ramps back to target.
//  cpu_vol_wr_stb data=10 same cycle as cw click -> target=10, irq stays 0; data=300-equivalent clamp checked with VOL_MAX=200.
//  Reverse goal mid-ramp (UP at vol_out=50 -> target 20) -> FSM DOWN, no extra up step; reset mid-ramp -> vol_out=0, IDLE->UP.

Source files
------------

// File: rtl/panel_volume_ctrl.sv
// Front-panel volume/mute controller: encoder-driven target volume with step
// acceleration, mute toggle, CPU overrides, and a fixed-rate vol_out ramp.
module panel_volume_ctrl #(
  parameter int VOL_W        = 8,
  parameter int VOL_MAX      = 255,
  parameter int VOL_DEFAULT  = 128,
  parameter int ACCEL_WINDOW = 2400000,
  parameter int ACCEL_STEP   = 4,
  parameter int RAMP_DIV     = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_stb,
  input  logic             enc_click,
  input  logic             enc_clockwise,
  input  logic             enc_switch,
  input  logic             cpu_vol_wr_stb,
  input  logic [VOL_W-1:0] cpu_vol_wr_data,
  input  logic             cpu_mute_wr_stb,
  input  logic             cpu_mute_wr_data,
  input  logic             irq_ack,
  output logic [VOL_W-1:0] target_vol,
  output logic [VOL_W-1:0] vol_out,
  output logic             mute,
  output logic             ramping,
  output logic             vol_change_irq,
  output logic [1:0]       ramp_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

  localparam int TMR_W = $clog2(ACCEL_WINDOW + 1);
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(ACCEL_WINDOW);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [VOL_W:0]   MAX_V    = (VOL_W + 1)'(VOL_MAX);
  localparam logic [VOL_W:0]   ACC_V    = (VOL_W + 1)'(ACCEL_STEP);
  localparam logic [VOL_W:0]   ONE_V    = (VOL_W + 1)'(1);

  // Handshake: every input strobe is a single-cycle pulse with its qualifiers
  // valid in the same cycle; there is no back-pressure, all events are taken.
  logic [TMR_W-1:0] accel_tmr;
  logic             last_dir;
  logic             sw_last;
  logic             click_ev;
  logic             press_ev;
  logic             use_accel;
  logic [VOL_W:0]   step;
  logic [VOL_W:0]   sum;
  logic [VOL_W-1:0] enc_vol;
  logic [VOL_W-1:0] cpu_vol;
  logic             enc_vol_chg;
  logic             enc_mute_chg;

  assign click_ev  = enc_stb & enc_click;
  assign press_ev  = enc_stb & enc_switch & ~sw_last;
  assign use_accel = (last_dir == enc_clockwise) && (accel_tmr < TMR_SAT);
  assign step      = use_accel ? ACC_V : ONE_V;
  assign sum       = {1'b0, target_vol} + step;

  always_comb begin
    enc_vol = target_vol;
    if (enc_clockwise) begin
      enc_vol = (sum > MAX_V) ? MAX_V[VOL_W-1:0] : sum[VOL_W-1:0];
    end else begin
      enc_vol = ({1'b0, target_vol} < step) ? '0 : (target_vol - step[VOL_W-1:0]);
    end
  end

  assign cpu_vol      = ({1'b0, cpu_vol_wr_data} > MAX_V) ? MAX_V[VOL_W-1:0] : cpu_vol_wr_data;
  assign enc_vol_chg  = click_ev & ~cpu_vol_wr_stb & (enc_vol != target_vol);
  assign enc_mute_chg = press_ev & ~cpu_mute_wr_stb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_vol     <= VOL_W'(VOL_DEFAULT);
      mute           <= 1'b0;
      vol_change_irq <= 1'b0;
      sw_last        <= 1'b0;
      last_dir       <= 1'b0;
      accel_tmr      <= TMR_SAT;
    end else begin
      if (cpu_vol_wr_stb)     target_vol <= cpu_vol;
      else if (click_ev)      target_vol <= enc_vol;
      if (cpu_mute_wr_stb)    mute <= cpu_mute_wr_data;
      else if (press_ev)      mute <= ~mute;
      // Set has priority so a panel change racing an ack is never lost.
      if (enc_vol_chg || enc_mute_chg) vol_change_irq <= 1'b1;
      else if (irq_ack)                vol_change_irq <= 1'b0;
      if (enc_stb) sw_last <= enc_switch;
      if (click_ev) begin
        accel_tmr <= '0;
        last_dir  <= enc_clockwise;
      end else if (accel_tmr < TMR_SAT) begin
        accel_tmr <= accel_tmr + 1'b1;
      end
    end
  end

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nx;
  logic [VOL_W-1:0] vol_nx;
  logic [VOL_W-1:0] goal;

  assign goal = mute ? '0 : target_vol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div     <= '0;
      vol_out <= '0;
    end else begin
      state   <= state_nx;
      div     <= div_nx;
      vol_out <= vol_nx;
    end
  end

  // Direction follows the live goal each cycle; the divider is not restarted
  // on reversal so the step rate stays constant.
  always_comb begin
    state_nx = state;
    div_nx   = div;
    vol_nx   = vol_out;
    case (state)
      IDLE: begin
        div_nx = '0;
        if (goal > vol_out)      state_nx = UP;
        else if (goal < vol_out) state_nx = DOWN;
      end
      default: begin
        if (goal == vol_out) begin
          state_nx = IDLE;
          div_nx   = '0;
        end else begin
          state_nx = (goal > vol_out) ? UP : DOWN;
          if (div == DIV_LAST) begin
            div_nx = '0;
            vol_nx = (goal > vol_out) ? (vol_out + 1'b1) : (vol_out - 1'b1);
          end else begin
            div_nx = div + 1'b1;
          end
        end
      end
    endcase
  end

  assign ramping    = (state != IDLE);
  assign ramp_state = state;

endmodule
